// File: rtl/frac_ce_gen_pkg.sv
// Shared defaults, limits and the per-channel configuration record for frac_ce_gen.
// Config fields are sized for the widest supported accumulator; channels use the low ACC_W bits.
package frac_ce_gen_pkg;

  localparam int ACC_W_DEF       = 32;
  localparam int LOCK_CYCLES_DEF = 1024;
  localparam int NUM_CH_MAX      = 8;
  localparam int ACC_W_MAX       = 48;

  typedef struct packed {
    logic [ACC_W_MAX-1:0] incr;
    logic [ACC_W_MAX-1:0] phase;
    logic                 en;
  } ch_cfg_t;

  function automatic ch_cfg_t pack_cfg(input logic [ACC_W_MAX-1:0] incr,
                                       input logic [ACC_W_MAX-1:0] phase,
                                       input logic                 en);
    ch_cfg_t c;
    c.incr  = incr;
    c.phase = phase;
    c.en    = en;
    return c;
  endfunction

endpackage

// File: rtl/frac_ce_chan.sv
// One phase-accumulator channel: ce is the registered carry out of acc + incr, clk_out the new MSB.
// Load and sync both preload acc (from the written phase or the stored phase) and suppress ce that edge.
module frac_ce_chan
  import frac_ce_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic    refclk,
  input  logic    rst,
  input  logic    load,
  input  ch_cfg_t cfg,
  input  logic    sync,
  output logic    ce,
  output logic    clk_out
);

  logic [ACC_W-1:0] incr;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] acc;
  logic             en;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, incr};

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      incr    <= '0;
      phase   <= '0;
      en      <= 1'b0;
      acc     <= '0;
      ce      <= 1'b0;
      clk_out <= 1'b0;
    end else if (load) begin
      incr    <= cfg.incr[ACC_W-1:0];
      phase   <= cfg.phase[ACC_W-1:0];
      en      <= cfg.en;
      acc     <= cfg.phase[ACC_W-1:0];
      ce      <= 1'b0;
      clk_out <= cfg.phase[ACC_W-1];
    end else if (sync) begin
      acc     <= phase;
      ce      <= 1'b0;
      clk_out <= phase[ACC_W-1];
    end else if (en) begin
      acc     <= sum[ACC_W-1:0];
      ce      <= sum[ACC_W];
      clk_out <= sum[ACC_W-1];
    end else begin
      // Disabled: accumulator and square wave hold, pulses stop.
      ce <= 1'b0;
    end
  end

  generate
    if (ACC_W < ACC_W_MAX) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^{cfg.incr[ACC_W_MAX-1:ACC_W], cfg.phase[ACC_W_MAX-1:ACC_W]};
    end
  endgenerate

endmodule

// File: rtl/frac_ce_gen.sv
// Multi-channel fractional clock-enable generator with config decode and a configuration-stable lock flag.
// Writes to channel indices >= NUM_CH are dropped entirely and do not disturb locked.
module frac_ce_gen
  import frac_ce_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_incr,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic             cfg_hit;
  ch_cfg_t          wr_cfg;
  logic [CNT_W-1:0] lock_cnt;

  assign cfg_hit = cfg_we && (int'({29'd0, cfg_ch}) < NUM_CH);
  assign wr_cfg  = pack_cfg(ACC_W_MAX'(cfg_incr), ACC_W_MAX'(cfg_phase), cfg_en);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_load;
      assign ch_load = cfg_hit && (cfg_ch == 3'(i));

      frac_ce_chan #(
        .ACC_W (ACC_W)
      ) u_chan (
        .refclk  (refclk),
        .rst     (rst),
        .load    (ch_load),
        .cfg     (wr_cfg),
        .sync    (sync),
        .ce      (ce[i]),
        .clk_out (clk_out[i])
      );
    end
  endgenerate

  // Reset release counts as a configuration change, so the counter starts from zero.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (cfg_hit || sync) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (lock_cnt != CNT_W'(LOCK_CYCLES)) begin
      lock_cnt <= lock_cnt + CNT_W'(1);
      if (lock_cnt == CNT_W'(LOCK_CYCLES - 1))
        locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frac_ce_gen.sv
// Self-checking bench for frac_ce_gen (ACC_W=8, LOCK_CYCLES=16, NUM_CH=4) against an arithmetic channel model.
module tb_frac_ce_gen;

  localparam int NCH  = 4;
  localparam int AW   = 8;
  localparam int LC   = 16;
  localparam int MOD  = 1 << AW;
  localparam int HALF = 1 << (AW - 1);

  logic           refclk = 1'b0;
  logic           rst;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [AW-1:0]  cfg_incr;
  logic [AW-1:0]  cfg_phase;
  logic           cfg_en;
  logic           sync;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] clk_out;
  logic           locked;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: accumulator value as an integer in [0, 2^AW).
  int             m_acc[NCH];
  int             m_incr[NCH];
  int             m_phase[NCH];
  bit             m_en[NCH];
  logic [NCH-1:0] m_ce;
  logic [NCH-1:0] m_clk;
  logic           m_locked;
  int             m_since;

  frac_ce_gen #(
    .NUM_CH      (NCH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_incr  (cfg_incr),
    .cfg_phase (cfg_phase),
    .cfg_en    (cfg_en),
    .sync      (sync),
    .ce        (ce),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  initial forever #5 refclk = ~refclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0; m_incr[i] = 0; m_phase[i] = 0; m_en[i] = 0;
    end
    m_ce = '0; m_clk = '0; m_locked = 1'b0; m_since = 0;
  endtask

  task automatic model_edge(input bit we, input int ch, input int incr, input int phase,
                            input bit en, input bit sy);
    bit valid;
    int s;
    valid = we && (ch < NCH);
    for (int i = 0; i < NCH; i++) begin
      if (valid && ch == i) begin
        m_incr[i] = incr; m_phase[i] = phase; m_en[i] = en;
        m_acc[i] = phase; m_ce[i] = 1'b0;
      end else if (sy) begin
        m_acc[i] = m_phase[i]; m_ce[i] = 1'b0;
      end else if (m_en[i]) begin
        s = m_acc[i] + m_incr[i];
        m_ce[i] = (s >= MOD);
        m_acc[i] = s % MOD;
      end else begin
        m_ce[i] = 1'b0;
      end
      m_clk[i] = (m_acc[i] >= HALF);
    end
    if (valid || sy) m_since = 0;
    else if (m_since < LC) m_since++;
    m_locked = (m_since >= LC);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, update the model, then sample point is #1 later.
  task automatic tick(input bit we, input int ch, input int incr, input int phase,
                      input bit en, input bit sy);
    @(negedge refclk);
    cfg_we = we; cfg_ch = 3'(ch); cfg_incr = AW'(incr); cfg_phase = AW'(phase);
    cfg_en = en; sync = sy;
    @(posedge refclk);
    if (!rst) model_edge(we, ch, incr, phase, en, sy);
    #1;
    cfg_we = 1'b0; sync = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    int first_lock;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_incr = '0; cfg_phase = '0;
    cfg_en = 1'b0; sync = 1'b0;
    model_reset();
    #12;
    n_cmp++;
    if ({ce, clk_out, locked} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ce=%b clk_out=%b locked=%b, expected all zero", ce, clk_out, locked);
    end
    @(posedge refclk); #1; rst = 1'b0;
    first_lock = -1;
    for (int k = 1; k <= 20; k++) begin
      idle();
      n_cmp++;
      if ({ce, clk_out, locked} !== {m_ce, m_clk, m_locked}) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got ce=%b clk=%b lk=%b, want ce=%b clk=%b lk=%b",
                 k, ce, clk_out, locked, m_ce, m_clk, m_locked);
      end
      if (locked === 1'b1 && first_lock < 0) first_lock = k;
    end
    n_cmp++;
    if (first_lock != LC) begin
      n_fail++;
      $display("FAIL reset_lock_latency: locked first at edge %0d, expected %0d", first_lock, LC);
    end
  endtask

  task automatic test_basic();
    int hits[$];
    tick(1'b1, 0, 64, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      idle();
      n_cmp++;
      if ({ce, clk_out, locked} !== {m_ce, m_clk, m_locked}) begin
        n_fail++;
        $display("FAIL basic edge %0d: got ce=%b clk=%b lk=%b, want ce=%b clk=%b lk=%b",
                 k, ce, clk_out, locked, m_ce, m_clk, m_locked);
      end
      if (ce[0] === 1'b1) hits.push_back(k);
    end
    n_cmp++;
    if (hits.size() != 3 || hits[0] != 4 || hits[1] != 8 || hits[2] != 12) begin
      n_fail++;
      $display("FAIL basic_ce_edges: got %p, expected 4 8 12", hits);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    tick(1'b1, 0, 64, 192, 1'b1, 1'b0);
    idle();
    n_cmp++;
    if (ce[0] !== 1'b1 || ce !== m_ce) begin
      n_fail++;
      $display("FAIL phase192_first_ce: ce=%b, expected %b with ce[0]=1", ce, m_ce);
    end
    tick(1'b1, 0, 255, 0, 1'b1, 1'b0);
    pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      idle();
      n_cmp++;
      if ({ce, clk_out} !== {m_ce, m_clk}) begin
        n_fail++;
        $display("FAIL incr255 edge %0d: got ce=%b clk=%b, want ce=%b clk=%b", k, ce, clk_out, m_ce, m_clk);
      end
      if (ce[0] === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 255) begin
      n_fail++;
      $display("FAIL incr255_count: got %0d pulses, expected 255", pulses);
    end
    tick(1'b1, 0, 0, 200, 1'b1, 1'b0);
    pulses = 0;
    for (int k = 1; k <= 50; k++) begin
      idle();
      if (ce[0] === 1'b1 || clk_out[0] !== 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL incr0_hold: %0d edges with ce[0] pulse or clk_out[0]!=1, expected 0", pulses);
    end
  endtask

  task automatic test_sync();
    int h0[$];
    int h1[$];
    tick(1'b1, 0, 64, 0, 1'b1, 1'b0);
    tick(1'b1, 1, 64, 128, 1'b1, 1'b0);
    repeat (3) idle();
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1);
    n_cmp++;
    if (ce !== m_ce || ce[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL sync_edge_ce: ce=%b, expected %b", ce, m_ce);
    end
    for (int k = 1; k <= 8; k++) begin
      idle();
      n_cmp++;
      if ({ce, clk_out, locked} !== {m_ce, m_clk, m_locked}) begin
        n_fail++;
        $display("FAIL sync edge %0d: got ce=%b clk=%b lk=%b, want ce=%b clk=%b lk=%b",
                 k, ce, clk_out, locked, m_ce, m_clk, m_locked);
      end
      if (ce[0] === 1'b1) h0.push_back(k);
      if (ce[1] === 1'b1) h1.push_back(k);
    end
    n_cmp++;
    if (h1.size() != 2 || h1[0] != 2 || h1[1] != 6 || h0.size() != 2 || h0[0] != 4 || h0[1] != 8) begin
      n_fail++;
      $display("FAIL sync_alignment: ce[0] at %p (want 4 8), ce[1] at %p (want 2 6)", h0, h1);
    end
  endtask

  task automatic test_disable();
    int bad;
    tick(1'b1, 0, 64, 128, 1'b0, 1'b0);
    bad = 0;
    for (int k = 1; k <= 20; k++) begin
      idle();
      if (ce[0] !== 1'b0 || clk_out[0] !== 1'b1) bad++;
      n_cmp++;
      if ({ce, clk_out} !== {m_ce, m_clk}) begin
        n_fail++;
        $display("FAIL disable edge %0d: got ce=%b clk=%b, want ce=%b clk=%b", k, ce, clk_out, m_ce, m_clk);
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL disable_freeze: %0d edges with ce[0]=1 or clk_out[0] moved, expected 0", bad);
    end
  endtask

  task automatic test_lock();
    int first_lock;
    repeat (20) idle();
    n_cmp++;
    if (locked !== 1'b1 || m_locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_idle: locked=%b, expected 1", locked);
    end
    tick(1'b1, 2, 32, 16, 1'b1, 1'b0);
    n_cmp++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_drop: locked=%b after write edge, expected 0", locked);
    end
    first_lock = -1;
    for (int k = 1; k <= 20; k++) begin
      idle();
      if (locked === 1'b1 && first_lock < 0) first_lock = k;
    end
    n_cmp++;
    if (first_lock != LC) begin
      n_fail++;
      $display("FAIL lock_return: locked at edge %0d after write, expected %0d", first_lock, LC);
    end
    tick(1'b1, 5, 99, 77, 1'b1, 1'b0);
    n_cmp++;
    if ({ce, clk_out, locked} !== {m_ce, m_clk, 1'b1}) begin
      n_fail++;
      $display("FAIL lock_bad_ch: got ce=%b clk=%b lk=%b, want ce=%b clk=%b lk=1",
               ce, clk_out, locked, m_ce, m_clk);
    end
  endtask

  task automatic test_reset_mid();
    int first_lock;
    int pulses;
    tick(1'b1, 3, 128, 0, 1'b1, 1'b0);
    repeat (3) idle();
    @(posedge refclk); #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({ce, clk_out, locked} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: ce=%b clk_out=%b locked=%b, expected all zero", ce, clk_out, locked);
    end
    repeat (2) @(posedge refclk);
    #1; rst = 1'b0;
    first_lock = -1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      idle();
      if (|ce) pulses++;
      if (locked === 1'b1 && first_lock < 0) first_lock = k;
    end
    n_cmp++;
    if (pulses != 0 || first_lock != LC) begin
      n_fail++;
      $display("FAIL mid_reset_release: %0d ce edges (want 0), locked at edge %0d (want %0d)",
               pulses, first_lock, LC);
    end
  endtask

  task automatic test_random();
    bit we;
    bit sy;
    for (int k = 0; k < 400; k++) begin
      we = ($urandom_range(0, 9) == 0);
      sy = ($urandom_range(0, 29) == 0);
      tick(we, int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)),
           int'($urandom_range(0, MOD - 1)), ($urandom_range(0, 4) != 0), sy);
      n_cmp++;
      if ({ce, clk_out, locked} !== {m_ce, m_clk, m_locked}) begin
        n_fail++;
        $display("FAIL random step %0d: got ce=%b clk=%b lk=%b, want ce=%b clk=%b lk=%b",
                 k, ce, clk_out, locked, m_ce, m_clk, m_locked);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_sync();
    test_disable();
    test_lock();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_ce_gen.md
FRAC_CE_GEN -- requirements
Module: frac_ce_gen

Interface
- REQ-001 SHALL have parameter NUM_CH, default 4, number of output channels (1..8).
- REQ-002 SHALL have parameter ACC_W, default 32, phase-accumulator width (8..48).
- REQ-003 SHALL have parameter LOCK_CYCLES, default 1024, settle count before locked asserts (>=2).
- REQ-004 SHALL have port: refclk  input  1  single clock for all logic, rising edge.
- REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-high.
- REQ-006 SHALL have port: cfg_we  input  1  one-cycle write strobe for channel configuration.
- REQ-007 SHALL have port: cfg_ch  input  3  target channel index.
- REQ-008 SHALL have port: cfg_incr  input  ACC_W  frequency word.
- REQ-009 SHALL have port: cfg_phase  input  ACC_W  accumulator preload (phase offset).
- REQ-010 SHALL have port: cfg_en  input  1  channel run enable.
- REQ-011 SHALL have port: sync  input  1  realign all channels to their stored phases.
- REQ-012 SHALL have port: ce  output  NUM_CH  one-cycle clock-enable pulse per channel.
- REQ-013 SHALL have port: clk_out  output  NUM_CH  registered accumulator MSB per channel (square wave).
- REQ-014 SHALL have port: locked  output  1  high when configuration has been stable LOCK_CYCLES cycles.

Function
- REQ-015 SHALL keep per channel registers incr, phase, en and acc (ACC_W bits each).
- REQ-016 SHALL, each edge with en=1 and no load, perform {carry, acc} <= acc + incr (ACC_W+1-bit sum) and ce[i] <= carry.
- REQ-017 SHALL yield output rate f_refclk * incr / 2^ACC_W; ce high exactly one cycle per wrap.
- REQ-018 SHALL set clk_out[i] <= MSB of the updated acc on the same edge.
- REQ-019 SHALL, on cfg_we with cfg_ch < NUM_CH, load incr, phase and en from the cfg inputs, set acc <= cfg_phase and ce[ch] <= 0 on that edge.
- REQ-020 SHALL ignore cfg_we when cfg_ch >= NUM_CH: no register changes and no locked drop.
- REQ-021 SHALL, on sync, set acc <= stored phase and ce <= 0 for every channel on the same edge.
- REQ-022 SHALL, on simultaneous sync and valid cfg_we, load the written channel from cfg_phase and the other channels from their stored phases.
- REQ-023 SHALL, with en=0, hold acc and clk_out and drive ce[i]=0.
- REQ-024 SHALL, with incr=0, never pulse ce; clk_out holds the MSB of the phase.
- REQ-025 SHALL keep a lock counter that clears, with locked <= 0, on every valid cfg_we or sync edge.
- REQ-026 SHALL otherwise increment the lock counter up to saturation, and assert locked on the edge the count reaches LOCK_CYCLES.
- REQ-027 SHALL let channels run regardless of locked; locked is status only.

Reset
- REQ-028 SHALL, while rst=1, asynchronously clear acc, incr, phase, en, ce, clk_out, locked and the lock counter to 0.
- REQ-029 SHALL treat reset release as a configuration change: locked asserts LOCK_CYCLES edges after deassertion.
- REQ-030 SHALL, on reset mid-operation, discard the pulse in progress; no ce is emitted until a channel is configured.

Structure
- REQ-031 SHALL place default ACC_W, default LOCK_CYCLES, NUM_CH limit and the channel-config struct typedef (incr, phase, en) in package frac_ce_gen_pkg.
- REQ-032 SHALL implement one accumulator channel as sub-module frac_ce_chan, instantiated NUM_CH times.
- REQ-033 SHALL keep lock counter and cfg decode in the top level.

Verification (ACC_W=8, LOCK_CYCLES=16, NUM_CH=4)
- REQ-034 SHALL check ch0 written with incr=64, phase=0, en=1: ce[0] high after edges 4, 8, 12 following the write; clk_out[0] period 4.
- REQ-035 SHALL check incr=64, phase=192: first ce after edge 1; incr=255: 255 pulses per 256 cycles; incr=0: no pulses.
- REQ-036 SHALL check ch0 phase=0 and ch1 phase=128, both incr=64, then sync: ce[1] after edge 2, ce[0] after edge 4, both period 4.
- REQ-037 SHALL check locked: it drops the edge after cfg_we, returns high exactly 16 edges later, and a write with cfg_ch=5 leaves it high.
- REQ-038 SHALL check rst asserted mid-run: all outputs 0 immediately, and locked returns 16 edges after release.
- REQ-039 SHALL check en=0 written to a running channel: ce stays 0 and acc and clk_out freeze.
